// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcode constants,
// IR field positions, sequencer states and ALU select indices.
package cpu_ctrl_pkg;

   localparam int OPC_LSB = 27;
   localparam int OPC_W   = 5;
   localparam int RA_LSB  = 23;
   localparam int RB_LSB  = 19;
   localparam int RC_LSB  = 15;

   localparam logic [OPC_W-1:0] OP_ADD  = 5'b00000;
   localparam logic [OPC_W-1:0] OP_SUB  = 5'b00001;
   localparam logic [OPC_W-1:0] OP_SHR  = 5'b00010;
   localparam logic [OPC_W-1:0] OP_SHL  = 5'b00011;
   localparam logic [OPC_W-1:0] OP_ROR  = 5'b00100;
   localparam logic [OPC_W-1:0] OP_ROL  = 5'b00101;
   localparam logic [OPC_W-1:0] OP_AND  = 5'b00110;
   localparam logic [OPC_W-1:0] OP_OR   = 5'b00111;
   localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
   localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
   localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
   localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
   localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      S_RST, T0, T1, T2, T3, T4, T5, T6, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      CL_ALU, CL_MULDIV, CL_UNARY, CL_HALT, CL_ILLEGAL
   } iclass_t;

   // Bit positions inside the one-hot ALU select vector.
   localparam int ALU_W   = 12;
   localparam int SEL_ADD = 0;
   localparam int SEL_SUB = 1;
   localparam int SEL_MUL = 2;
   localparam int SEL_DIV = 3;
   localparam int SEL_SHR = 4;
   localparam int SEL_SHL = 5;
   localparam int SEL_ROR = 6;
   localparam int SEL_ROL = 7;
   localparam int SEL_AND = 8;
   localparam int SEL_OR  = 9;
   localparam int SEL_NEG = 10;
   localparam int SEL_NOT = 11;

   function automatic logic [ALU_W-1:0] alu_onehot(input int idx);
      return ALU_W'(1) << idx;
   endfunction

endpackage

// File: rtl/ir_decoder.sv
// Combinational instruction decoder: classifies the opcode, picks the ALU
// select and expands the three register fields into one-hot selects.
module ir_decoder
   import cpu_ctrl_pkg::*;
#(
   parameter int BITS      = 32,
   parameter int REGISTERS = 16
) (
   input  logic [BITS-1:0]      i_ir,
   output iclass_t              o_class,
   output logic [ALU_W-1:0]     o_alu_sel,
   output logic [REGISTERS-1:0] o_ra_dec,
   output logic [REGISTERS-1:0] o_rb_dec,
   output logic [REGISTERS-1:0] o_rc_dec
);

   localparam int RW = $clog2(REGISTERS);

   logic [OPC_W-1:0] w_opc;
   logic [RW-1:0]    w_ra;
   logic [RW-1:0]    w_rb;
   logic [RW-1:0]    w_rc;
   logic             w_unused_low;

   assign w_opc        = i_ir[OPC_LSB +: OPC_W];
   assign w_ra         = i_ir[RA_LSB +: RW];
   assign w_rb         = i_ir[RB_LSB +: RW];
   assign w_rc         = i_ir[RC_LSB +: RW];
   assign w_unused_low = ^i_ir[RC_LSB-1:0];

   always_comb begin
      o_class   = CL_ILLEGAL;
      o_alu_sel = '0;
      case (w_opc)
         OP_ADD:  begin o_class = CL_ALU;    o_alu_sel = alu_onehot(SEL_ADD); end
         OP_SUB:  begin o_class = CL_ALU;    o_alu_sel = alu_onehot(SEL_SUB); end
         OP_SHR:  begin o_class = CL_ALU;    o_alu_sel = alu_onehot(SEL_SHR); end
         OP_SHL:  begin o_class = CL_ALU;    o_alu_sel = alu_onehot(SEL_SHL); end
         OP_ROR:  begin o_class = CL_ALU;    o_alu_sel = alu_onehot(SEL_ROR); end
         OP_ROL:  begin o_class = CL_ALU;    o_alu_sel = alu_onehot(SEL_ROL); end
         OP_AND:  begin o_class = CL_ALU;    o_alu_sel = alu_onehot(SEL_AND); end
         OP_OR:   begin o_class = CL_ALU;    o_alu_sel = alu_onehot(SEL_OR);  end
         OP_MUL:  begin o_class = CL_MULDIV; o_alu_sel = alu_onehot(SEL_MUL); end
         OP_DIV:  begin o_class = CL_MULDIV; o_alu_sel = alu_onehot(SEL_DIV); end
         OP_NEG:  begin o_class = CL_UNARY;  o_alu_sel = alu_onehot(SEL_NEG); end
         OP_NOT:  begin o_class = CL_UNARY;  o_alu_sel = alu_onehot(SEL_NOT); end
         OP_HALT: begin o_class = CL_HALT; end
         default: begin o_class = CL_ILLEGAL; end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < REGISTERS; gi++) begin : g_reg_dec
         assign o_ra_dec[gi] = (w_ra == RW'(gi));
         assign o_rb_dec[gi] = (w_rb == RW'(gi));
         assign o_rc_dec[gi] = (w_rc == RW'(gi));
      end
   endgenerate

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2), decode in T3 and execute steps for
// ALU, multiply/divide and unary instructions; outputs are Moore decoded.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int BITS      = 32,
   parameter int REGISTERS = 16
) (
   input  logic                 Clock,
   input  logic                 reset,
   input  logic [BITS-1:0]      IRVal,
   input  logic                 mem_ready,
   output logic [REGISTERS-1:0] GPRin,
   output logic [REGISTERS-1:0] GPRout,
   output logic                 PCin,
   output logic                 IRin,
   output logic                 RYin,
   output logic                 RZin,
   output logic                 MARin,
   output logic                 HIin,
   output logic                 LOin,
   output logic                 MDRin,
   output logic                 Read,
   output logic                 MDRout,
   output logic                 LOout,
   output logic                 HIout,
   output logic                 Zhighout,
   output logic                 Zlowout,
   output logic                 PCout,
   output logic                 ADD,
   output logic                 SUB,
   output logic                 MUL,
   output logic                 DIV,
   output logic                 SHR,
   output logic                 SHL,
   output logic                 ROR,
   output logic                 ROL,
   output logic                 AND,
   output logic                 OR,
   output logic                 NEGATE,
   output logic                 NOT,
   output logic                 IncPC,
   output logic                 run,
   output logic                 illegal
);

   state_t               r_state;
   state_t               w_next;
   logic                 r_t1_wait;
   iclass_t              w_class;
   logic [ALU_W-1:0]     w_alu_sel;
   logic [ALU_W-1:0]     w_alu;
   logic [REGISTERS-1:0] w_ra;
   logic [REGISTERS-1:0] w_rb;
   logic [REGISTERS-1:0] w_rc;
   logic                 w_op_en;

   ir_decoder #(
      .BITS      (BITS),
      .REGISTERS (REGISTERS)
   ) u_ir_decoder (
      .i_ir      (IRVal),
      .o_class   (w_class),
      .o_alu_sel (w_alu_sel),
      .o_ra_dec  (w_ra),
      .o_rb_dec  (w_rb),
      .o_rc_dec  (w_rc)
   );

   // r_t1_wait marks the repeat cycles of a stalled fetch read, so PCin
   // fires only on the cycle T1 is first entered.
   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         r_state   <= S_RST;
         r_t1_wait <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_t1_wait <= (r_state == T1) && !mem_ready;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RST: w_next = T0;
         T0:    w_next = T1;
         T1:    if (mem_ready) w_next = T2;
         T2:    w_next = T3;
         T3: begin
            case (w_class)
               CL_HALT:    w_next = S_HALT;
               CL_ILLEGAL: w_next = T0;
               default:    w_next = T4;
            endcase
         end
         T4:     w_next = (w_class == CL_UNARY) ? T0 : T5;
         T5:     w_next = (w_class == CL_MULDIV) ? T6 : T0;
         T6:     w_next = T0;
         S_HALT: w_next = S_HALT;
         default: w_next = S_RST;
      endcase
   end

   always_comb begin
      GPRin    = '0;
      GPRout   = '0;
      PCin     = 1'b0;
      IRin     = 1'b0;
      RYin     = 1'b0;
      RZin     = 1'b0;
      MARin    = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      MDRin    = 1'b0;
      Read     = 1'b0;
      MDRout   = 1'b0;
      LOout    = 1'b0;
      HIout    = 1'b0;
      Zhighout = 1'b0;
      Zlowout  = 1'b0;
      PCout    = 1'b0;
      IncPC    = 1'b0;
      illegal  = 1'b0;
      w_op_en  = 1'b0;
      case (r_state)
         T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            RZin  = 1'b1;
         end
         T1: begin
            Zlowout = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
            PCin    = !r_t1_wait;
         end
         T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         T3: begin
            case (w_class)
               CL_ALU: begin
                  GPRout = w_rb;
                  RYin   = 1'b1;
               end
               CL_MULDIV: begin
                  GPRout = w_ra;
                  RYin   = 1'b1;
               end
               CL_UNARY: begin
                  GPRout  = w_rb;
                  w_op_en = 1'b1;
                  RZin    = 1'b1;
               end
               CL_ILLEGAL: illegal = 1'b1;
               default: ;
            endcase
         end
         T4: begin
            case (w_class)
               CL_ALU: begin
                  GPRout  = w_rc;
                  w_op_en = 1'b1;
                  RZin    = 1'b1;
               end
               CL_MULDIV: begin
                  GPRout  = w_rb;
                  w_op_en = 1'b1;
                  RZin    = 1'b1;
               end
               CL_UNARY: begin
                  Zlowout = 1'b1;
                  GPRin   = w_ra;
               end
               default: ;
            endcase
         end
         T5: begin
            case (w_class)
               CL_ALU: begin
                  Zlowout = 1'b1;
                  GPRin   = w_ra;
               end
               CL_MULDIV: begin
                  Zlowout = 1'b1;
                  LOin    = 1'b1;
               end
               default: ;
            endcase
         end
         T6: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
         end
         default: ;
      endcase
   end

   assign run   = (r_state != S_RST) && (r_state != S_HALT);
   assign w_alu = w_op_en ? w_alu_sel : '0;

   assign ADD    = w_alu[SEL_ADD];
   assign SUB    = w_alu[SEL_SUB];
   assign MUL    = w_alu[SEL_MUL];
   assign DIV    = w_alu[SEL_DIV];
   assign SHR    = w_alu[SEL_SHR];
   assign SHL    = w_alu[SEL_SHL];
   assign ROR    = w_alu[SEL_ROR];
   assign ROL    = w_alu[SEL_ROL];
   assign AND    = w_alu[SEL_AND];
   assign OR     = w_alu[SEL_OR];
   assign NEGATE = w_alu[SEL_NEG];
   assign NOT    = w_alu[SEL_NOT];

endmodule
